// File: rtl/dbus_arbiter_if.sv
// Command/response bundle for one side of the data-bus arbiter (requester or memory).
// Pure wiring, no latency.
// Command is valid/ready; response is a ready-less one-cycle valid pulse.
interface dbus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_W-1:0]     cmd_addr;
   logic                  cmd_we;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [DATA_W/8-1:0]   cmd_wstrb;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;

   // Master issues commands and consumes responses.
   modport master (
      output cmd_valid, cmd_addr, cmd_we, cmd_wdata, cmd_wstrb,
      input  cmd_ready, rsp_valid, rsp_rdata
   );

   // Slave accepts commands and produces responses.
   modport slave (
      input  cmd_valid, cmd_addr, cmd_we, cmd_wdata, cmd_wstrb,
      output cmd_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-port arbiter (CPU dbus = p0, framebuffer fetch = p1) onto one data-memory port, one transaction in flight.
// Latency: read accept c0 -> mem cmd c1 -> rsp routed back c3 with 0-wait memory; write returns to idle at c2.
// Backpressure: requesters see ready only in IDLE for the granted port; mem_cmd_valid holds until mem_cmd_ready.
module dbus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int ARB_MODE     = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clk_i,
   input  logic           rst_n,
   dbus_arbiter_if.slave  p0,
   dbus_arbiter_if.slave  p1,
   dbus_arbiter_if.master mem,
   output logic           err_o
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic                port_q,   port_d;     // requester that owns the in-flight command
   logic                rr_ptr_q, rr_ptr_d;   // 1 = port 1 wins the next tie
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic                we_q,     we_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [STRB_W-1:0]   wstrb_q,  wstrb_d;
   logic                mem_vld_q, mem_vld_d;
   logic                rsp0_vld_q, rsp0_vld_d;
   logic                rsp1_vld_q, rsp1_vld_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;
   logic                err_q,    err_d;

   logic                grant0;
   logic                grant1;
   logic                accept;

   // Pick a winner among the valid requesters; a lone requester always wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (p0.cmd_valid && p1.cmd_valid) begin
         if (ARB_MODE == 0) begin
            grant1 = rr_ptr_q;
         end else begin
            grant1 = (starve_q == STARVE_MAX);
         end
         grant0 = ~grant1;
      end else begin
         grant0 = p0.cmd_valid;
         grant1 = p1.cmd_valid;
      end
   end

   assign accept       = (state_q == S_IDLE) && (grant0 || grant1);
   assign p0.cmd_ready = (state_q == S_IDLE) && grant0;
   assign p1.cmd_ready = (state_q == S_IDLE) && grant1;

   // Next-state for the FSM, latched command, arbitration history and response routing.
   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      rr_ptr_d   = rr_ptr_q;
      starve_d   = starve_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      mem_vld_d  = mem_vld_q;
      rsp0_vld_d = 1'b0;
      rsp1_vld_d = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_ISSUE;
               mem_vld_d = 1'b1;
               port_d    = grant1;
               addr_d    = grant1 ? p1.cmd_addr  : p0.cmd_addr;
               we_d      = grant1 ? p1.cmd_we    : p0.cmd_we;
               wdata_d   = grant1 ? p1.cmd_wdata : p0.cmd_wdata;
               wstrb_d   = grant1 ? p1.cmd_wstrb : p0.cmd_wstrb;
               // Favour whichever port did not just win.
               rr_ptr_d  = grant0;
               if (ARB_MODE != 0) begin
                  if (grant1) begin
                     starve_d = '0;
                  end else if (p1.cmd_valid && (starve_q != STARVE_MAX)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end
         S_ISSUE: begin
            if (mem.cmd_ready) begin
               mem_vld_d = 1'b0;
               state_d   = we_q ? S_IDLE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem.rsp_valid) begin
               state_d = S_IDLE;
               if (port_q) begin
                  rsp1_vld_d = 1'b1;
                  rdata1_d   = mem.rsp_rdata;
               end else begin
                  rsp0_vld_d = 1'b1;
                  rdata0_d   = mem.rsp_rdata;
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_vld_d = 1'b0;
         end
      endcase

      // A response with no read outstanding is a protocol error; it is dropped.
      if (mem.rsp_valid && (state_q != S_WAIT)) begin
         err_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         port_q     <= 1'b0;
         rr_ptr_q   <= 1'b0;
         starve_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         mem_vld_q  <= 1'b0;
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         rr_ptr_q   <= rr_ptr_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         mem_vld_q  <= mem_vld_d;
         rsp0_vld_q <= rsp0_vld_d;
         rsp1_vld_q <= rsp1_vld_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         err_q      <= err_d;
      end
   end

   assign mem.cmd_valid = mem_vld_q;
   assign mem.cmd_addr  = addr_q;
   assign mem.cmd_we    = we_q;
   assign mem.cmd_wdata = wdata_q;
   assign mem.cmd_wstrb = wstrb_q;

   assign p0.rsp_valid  = rsp0_vld_q;
   assign p0.rsp_rdata  = rdata0_q;
   assign p1.rsp_valid  = rsp1_vld_q;
   assign p1.rsp_rdata  = rdata1_q;

   assign err_o         = err_q;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: one round-robin and one fixed-priority instance.
// Memory model answers reads one cycle after accept with data = addr ^ 32'hDEAD_BEFF.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_dbus_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a_err, b_err;

   always #5 clk = ~clk;

   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_p0 ();
   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_p1 ();
   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_mem ();
   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_p0 ();
   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_p1 ();
   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_mem ();

   dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .STARVE_LIMIT(4)) dut_rr (
      .clk_i(clk), .rst_n(rst_n), .p0(a_p0), .p1(a_p1), .mem(a_mem), .err_o(a_err)
   );

   dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .STARVE_LIMIT(4)) dut_fp (
      .clk_i(clk), .rst_n(rst_n), .p0(b_p0), .p1(b_p1), .mem(b_mem), .err_o(b_err)
   );

   int n_vec  = 0;
   int n_miss = 0;

   int          a_g[$];
   int          b_g[$];
   logic [32:0] a_r[$];

   bit          a_auto    = 1'b1;
   logic        a_inj_vld = 1'b0;
   logic [31:0] a_inj_dat = 32'h0;

   int          exp2_g[4]  = '{0, 1, 0, 1};
   logic [32:0] exp2_r[4]  = '{{1'b0, 32'hDEAD_BFFF}, {1'b1, 32'hDEAD_BCFF},
                               {1'b0, 32'hDEAD_BFFF}, {1'b1, 32'hDEAD_BCFF}};
   int          exp3_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_p0.cmd_valid = 1'b0; a_p0.cmd_addr = '0; a_p0.cmd_we = 1'b0; a_p0.cmd_wdata = '0; a_p0.cmd_wstrb = '0;
      a_p1.cmd_valid = 1'b0; a_p1.cmd_addr = '0; a_p1.cmd_we = 1'b0; a_p1.cmd_wdata = '0; a_p1.cmd_wstrb = '0;
      b_p0.cmd_valid = 1'b0; b_p0.cmd_addr = '0; b_p0.cmd_we = 1'b0; b_p0.cmd_wdata = '0; b_p0.cmd_wstrb = '0;
      b_p1.cmd_valid = 1'b0; b_p1.cmd_addr = '0; b_p1.cmd_we = 1'b0; b_p1.cmd_wdata = '0; b_p1.cmd_wstrb = '0;
      a_mem.cmd_ready = 1'b1;
      b_mem.cmd_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      a_g.delete();
      b_g.delete();
      a_r.delete();
   endtask

   // Memory model for the round-robin instance (injection path used when a_auto is off).
   initial begin : a_mem_model
      logic        acc;
      logic [31:0] ad;
      a_mem.rsp_valid = 1'b0;
      a_mem.rsp_rdata = '0;
      forever begin
         @(negedge clk);
         acc = a_mem.cmd_valid && a_mem.cmd_ready && !a_mem.cmd_we;
         ad  = a_mem.cmd_addr;
         @(posedge clk);
         #1;
         if (a_auto) begin
            a_mem.rsp_valid = acc;
            a_mem.rsp_rdata = acc ? (ad ^ 32'hDEAD_BEFF) : 32'h0;
         end else begin
            a_mem.rsp_valid = a_inj_vld;
            a_mem.rsp_rdata = a_inj_dat;
         end
      end
   end

   // Memory model for the fixed-priority instance.
   initial begin : b_mem_model
      logic        acc;
      logic [31:0] ad;
      b_mem.rsp_valid = 1'b0;
      b_mem.rsp_rdata = '0;
      forever begin
         @(negedge clk);
         acc = b_mem.cmd_valid && b_mem.cmd_ready && !b_mem.cmd_we;
         ad  = b_mem.cmd_addr;
         @(posedge clk);
         #1;
         b_mem.rsp_valid = acc;
         b_mem.rsp_rdata = acc ? (ad ^ 32'hDEAD_BEFF) : 32'h0;
      end
   end

   // Record grants and responses; responses must never pulse on both ports together.
   always @(negedge clk) begin
      if (a_p0.cmd_valid && a_p0.cmd_ready) a_g.push_back(0);
      if (a_p1.cmd_valid && a_p1.cmd_ready) a_g.push_back(1);
      if (b_p0.cmd_valid && b_p0.cmd_ready) b_g.push_back(0);
      if (b_p1.cmd_valid && b_p1.cmd_ready) b_g.push_back(1);
      if (a_p0.rsp_valid) a_r.push_back({1'b0, a_p0.rsp_rdata});
      if (a_p1.rsp_valid) a_r.push_back({1'b1, a_p1.rsp_rdata});
      if (a_p0.rsp_valid || a_p1.rsp_valid) chk("a_rsp_onehot", a_p0.rsp_valid & a_p1.rsp_valid, 0);
      if (b_p0.rsp_valid || b_p1.rsp_valid) chk("b_rsp_onehot", b_p0.rsp_valid & b_p1.rsp_valid, 0);
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      int p1_rsps;

      // ---- reset state ----
      do_reset();
      @(negedge clk);
      chk("rst_a_ctl", {a_mem.cmd_valid, a_p0.cmd_ready, a_p1.cmd_ready, a_p0.rsp_valid, a_p1.rsp_valid, a_err}, 0);
      chk("rst_a_cmd", {a_mem.cmd_addr, a_mem.cmd_we, a_mem.cmd_wdata, a_mem.cmd_wstrb}, 0);
      chk("rst_a_rdata", {a_p0.rsp_rdata, a_p1.rsp_rdata}, 0);
      chk("rst_b_ctl", {b_mem.cmd_valid, b_p0.cmd_ready, b_p1.cmd_ready, b_p0.rsp_valid, b_p1.rsp_valid, b_err}, 0);

      // ---- 1: single p0 read, minimum latency ----
      do_reset();
      a_p0.cmd_valid = 1'b1; a_p0.cmd_addr = 32'h0000_0010; a_p0.cmd_we = 1'b0;
      @(negedge clk);
      chk("t1_p0_ready_c0", a_p0.cmd_ready, 1);
      chk("t1_p1_ready_c0", a_p1.cmd_ready, 0);
      tick();
      a_p0.cmd_valid = 1'b0;
      @(negedge clk);
      chk("t1_mem_cmd_c1", {a_mem.cmd_valid, a_mem.cmd_we, a_mem.cmd_addr}, {1'b1, 1'b0, 32'h0000_0010});
      chk("t1_p0_ready_busy", a_p0.cmd_ready, 0);
      tick();
      @(negedge clk);
      chk("t1_no_rsp_c2", a_p0.rsp_valid, 0);
      tick();
      @(negedge clk);
      chk("t1_rsp_c3", {a_p0.rsp_valid, a_p1.rsp_valid}, 2'b10);
      chk("t1_rdata_c3", a_p0.rsp_rdata, 32'hDEAD_BEEF);
      tick();
      @(negedge clk);
      chk("t1_rdata_hold", {a_p0.rsp_valid, a_p0.rsp_rdata}, {1'b0, 32'hDEAD_BEEF});
      chk("t1_p1_rdata", a_p1.rsp_rdata, 0);
      tick();
      chk("t1_rsp_count", a_r.size(), 1);

      // ---- 2: round-robin with both ports held valid ----
      do_reset();
      a_p0.cmd_valid = 1'b1; a_p0.cmd_addr = 32'h0000_0100; a_p0.cmd_we = 1'b0;
      a_p1.cmd_valid = 1'b1; a_p1.cmd_addr = 32'h0000_0200; a_p1.cmd_we = 1'b0;
      for (n = 0; n < 100 && a_g.size() < 4; n++) tick();
      a_p0.cmd_valid = 1'b0;
      a_p1.cmd_valid = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("t2_grant_count", a_g.size(), 4);
      chk("t2_rsp_count", a_r.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < a_g.size()) chk($sformatf("t2_grant%0d", i), a_g[i], exp2_g[i]);
         if (i < a_r.size()) chk($sformatf("t2_rsp%0d", i), a_r[i], exp2_r[i]);
      end

      // ---- 3: fixed priority with starvation guard ----
      do_reset();
      b_p0.cmd_valid = 1'b1; b_p0.cmd_addr = 32'h0000_0300; b_p0.cmd_we = 1'b1;
      b_p0.cmd_wdata = 32'h1111_1111; b_p0.cmd_wstrb = 4'hF;
      b_p1.cmd_valid = 1'b1; b_p1.cmd_addr = 32'h0000_0400; b_p1.cmd_we = 1'b1;
      b_p1.cmd_wdata = 32'h2222_2222; b_p1.cmd_wstrb = 4'hF;
      for (n = 0; n < 200 && b_g.size() < 10; n++) tick();
      b_p0.cmd_valid = 1'b0;
      b_p1.cmd_valid = 1'b0;
      tick();
      chk("t3_grant_count", b_g.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < b_g.size()) chk($sformatf("t3_grant%0d", i), b_g[i], exp3_g[i]);
      end

      // ---- 4: p1 write with memory stalling ----
      do_reset();
      a_mem.cmd_ready = 1'b0;
      a_p1.cmd_valid = 1'b1; a_p1.cmd_addr = 32'h1000_0000; a_p1.cmd_we = 1'b1;
      a_p1.cmd_wdata = 32'h0000_0777; a_p1.cmd_wstrb = 4'hF;
      @(negedge clk);
      chk("t4_p1_ready", a_p1.cmd_ready, 1);
      tick();
      a_p1.cmd_valid = 1'b0;
      a_p1.cmd_addr = 32'hFFFF_FFFF; a_p1.cmd_wdata = 32'hFFFF_FFFF; a_p1.cmd_wstrb = 4'h0; a_p1.cmd_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t4_hold%0d", k),
             {a_mem.cmd_valid, a_mem.cmd_we, a_mem.cmd_addr, a_mem.cmd_wdata, a_mem.cmd_wstrb},
             {1'b1, 1'b1, 32'h1000_0000, 32'h0000_0777, 4'hF});
         tick();
      end
      a_mem.cmd_ready = 1'b1;
      @(negedge clk);
      chk("t4_valid_at_accept", a_mem.cmd_valid, 1);
      tick();
      a_p0.cmd_valid = 1'b1; a_p0.cmd_addr = 32'h0000_0020; a_p0.cmd_we = 1'b0;
      @(negedge clk);
      chk("t4_back_idle", {a_mem.cmd_valid, a_p0.cmd_ready}, 2'b01);
      tick();
      a_p0.cmd_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      p1_rsps = 0;
      foreach (a_r[i]) if (a_r[i][32]) p1_rsps++;
      chk("t4_no_p1_rsp", p1_rsps, 0);

      // ---- 5: reset during WAIT, then a stale response ----
      do_reset();
      a_auto = 1'b0;
      a_inj_vld = 1'b0;
      a_inj_dat = 32'hBAD0_0001;
      tick();
      a_p0.cmd_valid = 1'b1; a_p0.cmd_addr = 32'h0000_0030; a_p0.cmd_we = 1'b0;
      @(negedge clk);
      chk("t5_p0_ready", a_p0.cmd_ready, 1);
      tick();
      a_p0.cmd_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("t5_in_wait", {a_mem.cmd_valid, a_p0.cmd_ready, a_p1.cmd_ready}, 0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_post_rst", {a_err, a_p0.rsp_valid, a_mem.cmd_valid}, 0);
      a_inj_vld = 1'b1;
      tick();
      @(negedge clk);
      a_inj_vld = 1'b0;
      tick();
      @(negedge clk);
      chk("t5_err_set", a_err, 1);
      for (int k = 0; k < 3; k++) tick();
      @(negedge clk);
      chk("t5_err_sticky", a_err, 1);
      chk("t5_no_rsp", a_r.size(), 0);
      a_auto = 1'b1;

      // ---- 6: p1 blocked while p0 read is in flight ----
      do_reset();
      a_p0.cmd_valid = 1'b1; a_p0.cmd_addr = 32'h0000_0040; a_p0.cmd_we = 1'b0;
      @(negedge clk);
      chk("t6_p0_ready", a_p0.cmd_ready, 1);
      tick();
      a_p0.cmd_valid = 1'b0;
      a_p1.cmd_valid = 1'b1; a_p1.cmd_addr = 32'h0000_0050; a_p1.cmd_we = 1'b0;
      @(negedge clk);
      chk("t6_p1_blocked_issue", a_p1.cmd_ready, 0);
      tick();
      @(negedge clk);
      chk("t6_p1_blocked_wait", a_p1.cmd_ready, 0);
      tick();
      @(negedge clk);
      chk("t6_idle_c3", {a_p0.rsp_valid, a_p1.cmd_ready}, 2'b11);
      tick();
      a_p1.cmd_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("t6_rsp_count", a_r.size(), 2);
      if (a_r.size() > 0) chk("t6_rsp0", a_r[0], {1'b0, 32'hDEAD_BEBF});
      if (a_r.size() > 1) chk("t6_rsp1", a_r[1], {1'b1, 32'hDEAD_BEAF});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
